// File: rtl/wb_cmd_master.sv
// wb_cmd_master: turns one command handshake into a single Wishbone classic transfer and returns a response.
// Latency: response valid in the 2nd cycle after the accept edge for a zero-wait responder, +1 per wait state.
// Backpressure: one transfer outstanding; cmd_ready_o stays low until the response is taken with rsp_ready_i.
// Build option: define WB_CMD_MASTER_RETRY_EN to re-issue on rty_i (up to MAX_RETRIES times, 1 idle cycle between attempts).
module wb_cmd_master #(
    parameter int unsigned TIMEOUT_CYCLES = 255,
    parameter int unsigned MAX_RETRIES    = 3
) (
    input  logic        clk_i,
    input  logic        rst_i,
    // command channel
    input  logic        cmd_valid_i,
    output logic        cmd_ready_o,
    input  logic        cmd_we_i,
    input  logic [31:0] cmd_adr_i,
    input  logic [3:0]  cmd_sel_i,
    input  logic [31:0] cmd_dat_i,
    // response channel
    output logic        rsp_valid_o,
    input  logic        rsp_ready_i,
    output logic [31:0] rsp_dat_o,
    output logic [1:0]  rsp_status_o,
    // Wishbone initiator
    output logic        cyc_o,
    output logic        stb_o,
    output logic        we_o,
    output logic [31:0] adr_o,
    output logic [3:0]  sel_o,
    output logic [31:0] dat_o,
    input  logic [31:0] dat_i,
    input  logic        ack_i,
    input  logic        err_i,
    input  logic        rty_i
);

    localparam logic [1:0] ST_OK      = 2'b00;
    localparam logic [1:0] ST_ERR     = 2'b01;
    localparam logic [1:0] ST_TIMEOUT = 2'b10;
    localparam logic [1:0] ST_RTY_EXH = 2'b11;

    // Timeout compare value; the counter is fixed at 16 bits.
    localparam logic [15:0] TO_LIMIT = 16'(TIMEOUT_CYCLES);

    typedef enum logic [1:0] {
        S_IDLE,
        S_BUS,
        S_GAP,
        S_RESP
    } state_t;

    state_t      state;
    logic [15:0] to_cnt;

`ifdef WB_CMD_MASTER_RETRY_EN
    localparam int RW = (MAX_RETRIES < 1) ? 1 : $clog2(MAX_RETRIES + 1);
    logic [RW-1:0] retry_cnt;
`else
    // Retry count is irrelevant without the retry build; keep the parameter referenced.
    if (MAX_RETRIES > 32'hFFFF_FFFE) begin : g_retry_param_unused
    end
`endif

    logic        bus_done;
    logic        bus_retry;
    logic [1:0]  bus_status;
    logic [31:0] bus_rdat;

    // Resolve what the current bus cycle's sampled terminations mean: err > rty > ack > timeout.
    always_comb begin
        bus_done   = 1'b0;
        bus_retry  = 1'b0;
        bus_status = ST_OK;
        bus_rdat   = 32'h0;
        if (err_i) begin
            bus_done   = 1'b1;
            bus_status = ST_ERR;
        end else if (rty_i) begin
`ifdef WB_CMD_MASTER_RETRY_EN
            if (retry_cnt < RW'(MAX_RETRIES)) begin
                bus_retry = 1'b1;
            end else begin
                bus_done   = 1'b1;
                bus_status = ST_RTY_EXH;
            end
`else
            bus_done   = 1'b1;
            bus_status = ST_RTY_EXH;
`endif
        end else if (ack_i) begin
            bus_done   = 1'b1;
            bus_status = ST_OK;
            bus_rdat   = we_o ? 32'h0 : dat_i;
        end else if (to_cnt + 16'd1 == TO_LIMIT) begin
            bus_done   = 1'b1;
            bus_status = ST_TIMEOUT;
        end
    end

    // Transfer FSM with all outputs registered; reset drops the bus asynchronously.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state        <= S_IDLE;
            to_cnt       <= 16'h0;
            cmd_ready_o  <= 1'b0;
            rsp_valid_o  <= 1'b0;
            rsp_dat_o    <= 32'h0;
            rsp_status_o <= ST_OK;
            cyc_o        <= 1'b0;
            stb_o        <= 1'b0;
            we_o         <= 1'b0;
            adr_o        <= 32'h0;
            sel_o        <= 4'h0;
            dat_o        <= 32'h0;
`ifdef WB_CMD_MASTER_RETRY_EN
            retry_cnt    <= '0;
`endif
        end else begin
            case (state)
                S_IDLE: begin
                    cmd_ready_o <= 1'b1;
                    if (cmd_valid_i && cmd_ready_o) begin
                        cmd_ready_o <= 1'b0;
                        we_o        <= cmd_we_i;
                        adr_o       <= cmd_adr_i;
                        sel_o       <= cmd_sel_i;
                        dat_o       <= cmd_dat_i;
                        cyc_o       <= 1'b1;
                        stb_o       <= 1'b1;
                        to_cnt      <= 16'h0;
`ifdef WB_CMD_MASTER_RETRY_EN
                        retry_cnt   <= '0;
`endif
                        state       <= S_BUS;
                    end
                end
                S_BUS: begin
                    if (bus_done) begin
                        cyc_o        <= 1'b0;
                        stb_o        <= 1'b0;
                        rsp_valid_o  <= 1'b1;
                        rsp_status_o <= bus_status;
                        rsp_dat_o    <= bus_rdat;
                        state        <= S_RESP;
                    end else if (bus_retry) begin
                        cyc_o <= 1'b0;
                        stb_o <= 1'b0;
`ifdef WB_CMD_MASTER_RETRY_EN
                        retry_cnt <= retry_cnt + 1'b1;
`endif
                        state <= S_GAP;
                    end else begin
                        to_cnt <= to_cnt + 16'd1;
                    end
                end
                S_GAP: begin
                    // Re-issue with the same registered address/data/control.
                    cyc_o  <= 1'b1;
                    stb_o  <= 1'b1;
                    to_cnt <= 16'h0;
                    state  <= S_BUS;
                end
                S_RESP: begin
                    if (rsp_ready_i) begin
                        rsp_valid_o  <= 1'b0;
                        rsp_dat_o    <= 32'h0;
                        rsp_status_o <= ST_OK;
                        cmd_ready_o  <= 1'b1;
                        state        <= S_IDLE;
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_wb_cmd_master.sv
// tb_wb_cmd_master: randomized and directed checks of wb_cmd_master against a transaction-level model.
// Latency: n/a (testbench).
// Backpressure: the bench holds responses for a random number of cycles before taking them.
module tb_wb_cmd_master;

    localparam int TMO  = 8;
    localparam int MAXR = 3;
`ifdef WB_CMD_MASTER_RETRY_EN
    localparam bit RETRY_EN = 1'b1;
`else
    localparam bit RETRY_EN = 1'b0;
`endif

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b0;
    logic        cmd_valid_i = 1'b0;
    logic        cmd_ready_o;
    logic        cmd_we_i = 1'b0;
    logic [31:0] cmd_adr_i = '0;
    logic [3:0]  cmd_sel_i = '0;
    logic [31:0] cmd_dat_i = '0;
    logic        rsp_valid_o;
    logic        rsp_ready_i = 1'b0;
    logic [31:0] rsp_dat_o;
    logic [1:0]  rsp_status_o;
    logic        cyc_o, stb_o, we_o;
    logic [31:0] adr_o, dat_o;
    logic [3:0]  sel_o;
    logic [31:0] dat_i = '0;
    logic        ack_i = 1'b0, err_i = 1'b0, rty_i = 1'b0;

    int checks = 0;
    int errors = 0;

    wb_cmd_master #(.TIMEOUT_CYCLES(TMO), .MAX_RETRIES(MAXR)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o), .cmd_we_i(cmd_we_i),
        .cmd_adr_i(cmd_adr_i), .cmd_sel_i(cmd_sel_i), .cmd_dat_i(cmd_dat_i),
        .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i), .rsp_dat_o(rsp_dat_o),
        .rsp_status_o(rsp_status_o),
        .cyc_o(cyc_o), .stb_o(stb_o), .we_o(we_o), .adr_o(adr_o), .sel_o(sel_o), .dat_o(dat_o),
        .dat_i(dat_i), .ack_i(ack_i), .err_i(err_i), .rty_i(rty_i)
    );

    always #5 clk_i = ~clk_i;

    // Responder configuration: kind bits {rty, err, ack}; 0 means never respond.
    logic [2:0]  r_kind = 3'd1;
    int          r_waits = 0;
    logic [31:0] r_rdata = '0;

    // Expected bus fields and bus observations for the current transaction.
    logic        exp_we;
    logic [31:0] exp_adr, exp_dat;
    logic [3:0]  exp_sel;
    int attempts = 0, cyc_cycles = 0, gap_cycles = 0, unstable = 0, fld_bad = 0;
    bit in_txn = 0;
    bit prev_cyc = 0;
    int wcnt = 0;
    logic [68:0] a_snap;

    // Responder and bus monitor, acting mid-cycle.
    always @(negedge clk_i) begin
        bit hit;
        if (cyc_o && stb_o) begin
            if (!prev_cyc) begin
                attempts++;
                wcnt = 0;
                if (adr_o !== exp_adr || sel_o !== exp_sel || we_o !== exp_we || dat_o !== exp_dat)
                    fld_bad++;
                a_snap = {we_o, adr_o, sel_o, dat_o};
            end else if ({we_o, adr_o, sel_o, dat_o} !== a_snap) begin
                unstable++;
            end
            cyc_cycles++;
            hit   = (r_kind != 3'd0) && (wcnt == r_waits);
            ack_i = hit && r_kind[0];
            err_i = hit && r_kind[1];
            rty_i = hit && r_kind[2];
            dat_i = hit ? r_rdata : $urandom;
            wcnt++;
        end else begin
            ack_i = 1'b0; err_i = 1'b0; rty_i = 1'b0;
            dat_i = $urandom;
            if (in_txn && attempts > 0 && !rsp_valid_o) gap_cycles++;
        end
        prev_cyc = cyc_o;
    end

    // Transaction-level expectation derived from the termination rules.
    task automatic model(input logic [2:0] kind, input int waits, input bit we, input logic [31:0] rd,
                         output logic [1:0] st, output logic [31:0] d, output int n_att,
                         output int n_cyc, output int lat);
        if (kind == 3'd0 || waits >= TMO) begin
            st = 2'b10; d = 32'h0; n_att = 1; n_cyc = TMO;
        end else begin
            d = 32'h0;
            n_att = 1;
            if (kind[1]) st = 2'b01;
            else if (kind[2]) begin
                st = 2'b11;
                n_att = RETRY_EN ? MAXR + 1 : 1;
            end else begin
                st = 2'b00;
                d = we ? 32'h0 : rd;
            end
            n_cyc = (waits + 1) * n_att;
        end
        lat = n_cyc + (n_att - 1) + 1;
    endtask

    // Issue one command from a negedge, wait for the response, hold it, then take it.
    task automatic do_txn(input bit we, input logic [31:0] adr, input logic [3:0] sel, input logic [31:0] dat,
                          input int hold, output int lat, output logic [1:0] st, output logic [31:0] rd,
                          output bit held_ok, output int busy_rdy);
        int n;
        exp_we = we; exp_adr = adr; exp_sel = sel; exp_dat = dat;
        attempts = 0; cyc_cycles = 0; gap_cycles = 0; unstable = 0; fld_bad = 0; in_txn = 1;
        cmd_we_i = we; cmd_adr_i = adr; cmd_sel_i = sel; cmd_dat_i = dat; cmd_valid_i = 1'b1;
        n = 0;
        while (cmd_ready_o !== 1'b1 && n < 100) begin @(negedge clk_i); n++; end
        if (n >= 100) begin
            checks++; errors++;
            $display("FAIL accept_wait: cmd_ready_o=%b never high within 100 cycles, required 1", cmd_ready_o);
        end
        @(posedge clk_i);
        #1 cmd_valid_i = 1'b0;
        lat = 0; busy_rdy = 0;
        do begin
            @(negedge clk_i);
            lat++;
            if (cmd_ready_o) busy_rdy++;
        end while (rsp_valid_o !== 1'b1 && lat < 2000);
        if (lat >= 2000) begin
            checks++; errors++;
            $display("FAIL rsp_wait: rsp_valid_o=%b after 2000 cycles, required 1", rsp_valid_o);
        end
        st = rsp_status_o; rd = rsp_dat_o; held_ok = 1;
        repeat (hold) begin
            @(negedge clk_i);
            if (rsp_valid_o !== 1'b1 || rsp_status_o !== st || rsp_dat_o !== rd) held_ok = 0;
            if (cmd_ready_o) busy_rdy++;
        end
        rsp_ready_i = 1'b1;
        @(posedge clk_i);
        #1 rsp_ready_i = 1'b0;
        in_txn = 0;
        @(negedge clk_i);
    endtask

    task automatic test_reset;
        rst_i = 1'b0;
        repeat (3) @(negedge clk_i);
        checks++;
        if ({cyc_o, stb_o, we_o, adr_o, sel_o, dat_o} !== '0) begin
            errors++;
            $display("FAIL reset_bus: got cyc=%b stb=%b we=%b adr=%h sel=%h dat=%h, required all 0",
                     cyc_o, stb_o, we_o, adr_o, sel_o, dat_o);
        end
        checks++;
        if ({rsp_valid_o, rsp_dat_o, rsp_status_o, cmd_ready_o} !== '0) begin
            errors++;
            $display("FAIL reset_rsp: got rsp_valid=%b dat=%h status=%b cmd_ready=%b, required all 0",
                     rsp_valid_o, rsp_dat_o, rsp_status_o, cmd_ready_o);
        end
        rst_i = 1'b1;
        #1;
        checks++;
        if (cmd_ready_o !== 1'b0) begin
            errors++; $display("FAIL reset_release_ready: got %b, required 0 before first edge", cmd_ready_o);
        end
        @(posedge clk_i);
        #1;
        checks++;
        if (cmd_ready_o !== 1'b1) begin
            errors++; $display("FAIL reset_first_edge_ready: got %b, required 1", cmd_ready_o);
        end
        @(negedge clk_i);
    endtask

    task automatic test_zero_wait_write;
        int lat, br; logic [1:0] st; logic [31:0] rd; bit ok;
        r_kind = 3'b001; r_waits = 0; r_rdata = 32'hCAFE_F00D;
        do_txn(1'b1, 32'h2000_0010, 4'hF, 32'hDEADBEEF, 0, lat, st, rd, ok, br);
        checks++;
        if (lat !== 2) begin errors++; $display("FAIL zw_latency: got %0d, required 2", lat); end
        checks++;
        if (st !== 2'b00 || rd !== 32'h0) begin
            errors++; $display("FAIL zw_rsp: got status=%b dat=%h, required 00/00000000", st, rd);
        end
        checks++;
        if (attempts !== 1 || cyc_cycles !== 1 || fld_bad !== 0) begin
            errors++; $display("FAIL zw_bus: got attempts=%0d cyc=%0d field_errs=%0d, required 1/1/0",
                               attempts, cyc_cycles, fld_bad);
        end
        checks++;
        if (cmd_ready_o !== 1'b1 || rsp_valid_o !== 1'b0) begin
            errors++; $display("FAIL zw_return: got cmd_ready=%b rsp_valid=%b, required 1/0", cmd_ready_o, rsp_valid_o);
        end
    endtask

    task automatic test_read_wait3;
        int lat, br; logic [1:0] st; logic [31:0] rd; bit ok;
        r_kind = 3'b001; r_waits = 3; r_rdata = 32'h1234_5678;
        do_txn(1'b0, 32'h0000_0400, 4'h3, 32'h0BAD_0BAD, 1, lat, st, rd, ok, br);
        checks++;
        if (cyc_cycles !== 4 || unstable !== 0) begin
            errors++; $display("FAIL rd3_cyc: got cyc=%0d unstable=%0d, required 4/0", cyc_cycles, unstable);
        end
        checks++;
        if (st !== 2'b00 || rd !== 32'h1234_5678 || lat !== 5) begin
            errors++; $display("FAIL rd3_rsp: got status=%b dat=%h lat=%0d, required 00/12345678/5", st, rd, lat);
        end
    endtask

    task automatic test_timeout;
        int lat, br; logic [1:0] st; logic [31:0] rd; bit ok;
        r_kind = 3'b000; r_waits = 0;
        do_txn(1'b0, 32'h4000_0000, 4'hF, 32'h0, 0, lat, st, rd, ok, br);
        checks++;
        if (cyc_cycles !== TMO || st !== 2'b10 || rd !== 32'h0) begin
            errors++; $display("FAIL timeout: got cyc=%0d status=%b dat=%h, required %0d/10/00000000",
                               cyc_cycles, st, rd, TMO);
        end
        // Ack arriving on the very cycle the timeout would fire wins.
        r_kind = 3'b001; r_waits = TMO - 1; r_rdata = 32'h5A5A_A5A5;
        do_txn(1'b0, 32'h4000_0004, 4'hF, 32'h0, 0, lat, st, rd, ok, br);
        checks++;
        if (cyc_cycles !== TMO || st !== 2'b00 || rd !== 32'h5A5A_A5A5) begin
            errors++; $display("FAIL timeout_edge_ack: got cyc=%0d status=%b dat=%h, required %0d/00/5a5aa5a5",
                               cyc_cycles, st, rd, TMO);
        end
        r_kind = 3'b001; r_waits = 0; r_rdata = 32'h0000_1111;
        do_txn(1'b0, 32'h4000_0008, 4'h1, 32'h0, 0, lat, st, rd, ok, br);
        checks++;
        if (st !== 2'b00 || rd !== 32'h0000_1111 || lat !== 2) begin
            errors++; $display("FAIL after_timeout: got status=%b dat=%h lat=%0d, required 00/00001111/2", st, rd, lat);
        end
    endtask

    task automatic test_err_ack_hold;
        int lat, br; logic [1:0] st; logic [31:0] rd; bit ok;
        r_kind = 3'b011; r_waits = 1; r_rdata = 32'hFFFF_FFFF;
        do_txn(1'b0, 32'h8000_0000, 4'hF, 32'h0, 5, lat, st, rd, ok, br);
        checks++;
        if (st !== 2'b01 || rd !== 32'h0) begin
            errors++; $display("FAIL err_ack: got status=%b dat=%h, required 01/00000000", st, rd);
        end
        checks++;
        if (ok !== 1'b1 || br !== 0) begin
            errors++; $display("FAIL err_hold: got stable=%b busy_ready=%0d, required 1/0", ok, br);
        end
    endtask

    task automatic test_retry;
        int lat, br, n_att, n_cyc, e_lat; logic [1:0] st, e_st; logic [31:0] rd, e_d; bit ok;
        for (int w = 0; w < 3; w += 2) begin
            r_kind = 3'b100; r_waits = w;
            do_txn(1'b1, 32'h0000_0100 + w, 4'hC, 32'h7777_0000 + w, 0, lat, st, rd, ok, br);
            model(3'b100, w, 1'b1, 32'h0, e_st, e_d, n_att, n_cyc, e_lat);
            checks++;
            if (attempts !== n_att || gap_cycles !== n_att - 1 || cyc_cycles !== n_cyc) begin
                errors++; $display("FAIL retry_bus w=%0d: got att=%0d gaps=%0d cyc=%0d, required %0d/%0d/%0d",
                                   w, attempts, gap_cycles, cyc_cycles, n_att, n_att - 1, n_cyc);
            end
            checks++;
            if (st !== 2'b11 || rd !== 32'h0 || fld_bad !== 0 || lat !== e_lat) begin
                errors++; $display("FAIL retry_rsp w=%0d: got status=%b dat=%h field_errs=%0d lat=%0d, required 11/0/0/%0d",
                                   w, st, rd, fld_bad, lat, e_lat);
            end
        end
    endtask

    task automatic test_reset_mid;
        r_kind = 3'b000;
        cmd_we_i = 1'b0; cmd_adr_i = 32'h0000_0ABC; cmd_sel_i = 4'hF; cmd_dat_i = 32'h0;
        exp_we = 1'b0; exp_adr = 32'h0000_0ABC; exp_sel = 4'hF; exp_dat = 32'h0;
        cmd_valid_i = 1'b1;
        @(posedge clk_i);
        #1 cmd_valid_i = 1'b0;
        repeat (2) @(negedge clk_i);
        checks++;
        if (cyc_o !== 1'b1) begin errors++; $display("FAIL rstmid_pre: got cyc=%b, required 1", cyc_o); end
        rst_i = 1'b0;
        #1;
        checks++;
        if (cyc_o !== 1'b0 || stb_o !== 1'b0 || rsp_valid_o !== 1'b0) begin
            errors++; $display("FAIL rstmid_drop: got cyc=%b stb=%b rsp_valid=%b, required 0/0/0", cyc_o, stb_o, rsp_valid_o);
        end
        repeat (2) @(negedge clk_i);
        rst_i = 1'b1;
        @(posedge clk_i);
        #1;
        checks++;
        if (cmd_ready_o !== 1'b1 || cyc_o !== 1'b0 || rsp_valid_o !== 1'b0) begin
            errors++; $display("FAIL rstmid_release: got ready=%b cyc=%b rsp_valid=%b, required 1/0/0",
                               cmd_ready_o, cyc_o, rsp_valid_o);
        end
        repeat (4) @(negedge clk_i);
        checks++;
        if (rsp_valid_o !== 1'b0 || cyc_o !== 1'b0) begin
            errors++; $display("FAIL rstmid_no_rsp: got rsp_valid=%b cyc=%b, required 0/0", rsp_valid_o, cyc_o);
        end
    endtask

    task automatic test_random;
        int lat, br, n_att, n_cyc, e_lat, w, hold; logic [1:0] st, e_st; logic [31:0] rd, e_d, adr, dat;
        logic [3:0] sel; logic [2:0] kind; bit ok, we;
        for (int i = 0; i < 40; i++) begin
            kind = 3'($urandom_range(0, 7));
            w = $urandom_range(0, 10);
            we = 1'($urandom);
            adr = $urandom; dat = $urandom; sel = 4'($urandom);
            hold = $urandom_range(0, 3);
            r_kind = kind; r_waits = w; r_rdata = $urandom;
            model(kind, w, we, r_rdata, e_st, e_d, n_att, n_cyc, e_lat);
            do_txn(we, adr, sel, dat, hold, lat, st, rd, ok, br);
            checks++;
            if (st !== e_st || rd !== e_d || lat !== e_lat) begin
                errors++; $display("FAIL rand_rsp[%0d] kind=%b w=%0d we=%b: got st=%b dat=%h lat=%0d, required %b/%h/%0d",
                                   i, kind, w, we, st, rd, lat, e_st, e_d, e_lat);
            end
            checks++;
            if (attempts !== n_att || cyc_cycles !== n_cyc || gap_cycles !== n_att - 1 ||
                fld_bad !== 0 || unstable !== 0 || ok !== 1'b1 || br !== 0) begin
                errors++; $display("FAIL rand_bus[%0d]: got att=%0d cyc=%0d gaps=%0d fld=%0d unst=%0d held=%b br=%0d, required %0d/%0d/%0d/0/0/1/0",
                                   i, attempts, cyc_cycles, gap_cycles, fld_bad, unstable, ok, br,
                                   n_att, n_cyc, n_att - 1);
            end
        end
    endtask

    initial begin
        test_reset();
        test_zero_wait_write();
        test_read_wait3();
        test_timeout();
        test_err_ack_hold();
        test_retry();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
